// File: rtl/temp_alarm_ctrl.sv
// temp_alarm_ctrl: box-averages 2**AVG_LOG2 ADC samples and classifies each
// window average into NORMAL / WARN / ALARM. Escalation is debounced, while
// de-escalation is immediate once the average falls below the hysteresis margin.
module temp_alarm_ctrl #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [9:0]  WARN_TH  = 10'd37,
  parameter logic [9:0]  ALARM_TH = 10'd60,
  parameter logic [9:0]  HYST     = 10'd2,
  parameter int unsigned DEB      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sample,
  input  logic       sample_valid,
  output logic [9:0] temp_avg,
  output logic       avg_valid,
  output logic [1:0] led,
  output logic [1:0] level,
  output logic       alarm_pulse
);

  localparam int unsigned AW  = 10 + AVG_LOG2;
  localparam int unsigned CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned NS  = 1 << AVG_LOG2;
  localparam logic [9:0]  WARN_LO  = WARN_TH - HYST;
  localparam logic [9:0]  ALARM_LO = ALARM_TH - HYST;

  typedef enum logic [1:0] {NORMAL = 2'd0, WARN = 2'd1, ALARM = 2'd2} state_t;

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] sum;
  logic          last;

  state_t        state, state_n, target;
  logic [3:0]    deb, deb_n;

  // The accumulator is sized so a full window of 1023s cannot overflow.
  assign sum  = acc + AW'(sample);
  assign last = (cnt == CW'(NS - 1));

  // Window accumulation; the completing sample publishes the truncated mean and
  // restarts the window so a strobe in the very next cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      temp_avg  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        if (last) begin
          temp_avg  <= sum[AVG_LOG2 +: 10];
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Level requested by the current average; thresholds are strict "above".
  always_comb begin
    target = NORMAL;
    if (temp_avg > ALARM_TH)     target = ALARM;
    else if (temp_avg > WARN_TH) target = WARN;
  end

  // Next-state: debounced escalation, immediate hysteretic de-escalation.
  always_comb begin
    state_n = state;
    deb_n   = deb;
    if (avg_valid) begin
      if (target > state) begin
        if (deb + 4'd1 >= 4'(DEB)) begin
          state_n = target;
          deb_n   = '0;
        end else begin
          deb_n = deb + 4'd1;
        end
      end else begin
        deb_n = '0;
        case (state)
          ALARM: begin
            if (temp_avg <= WARN_LO)       state_n = NORMAL;
            else if (temp_avg <= ALARM_LO) state_n = WARN;
          end
          WARN: begin
            if (temp_avg <= WARN_LO) state_n = NORMAL;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  // State register; the pulse marks only the transition into ALARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NORMAL;
      deb         <= '0;
      alarm_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      deb         <= deb_n;
      alarm_pulse <= (state_n == ALARM) && (state != ALARM);
    end
  end

  assign level = state;
  assign led   = {state == ALARM, state != NORMAL};

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Bench for temp_alarm_ctrl: a table of whole windows with constant expected
// results, hand-written reset sequences, and a randomized run, all checked
// cycle by cycle against a window/rule-level reference model.
module tb_temp_alarm_ctrl;

  localparam int WTH = 37, ATH = 60, HY = 2, DEBN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic [9:0] temp_avg;
  logic       avg_valid;
  logic [1:0] led, level;
  logic       alarm_pulse;

  temp_alarm_ctrl #(.AVG_LOG2(2), .WARN_TH(10'd37), .ALARM_TH(10'd60),
                    .HYST(10'd2), .DEB(2)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .temp_avg(temp_avg), .avg_valid(avg_valid), .led(led), .level(level),
    .alarm_pulse(alarm_pulse));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  int win[$];
  int m_avg = 0, m_avgv = 0, m_level = 0, m_deb = 0, m_pulse = 0;
  int pulses_seen = 0, avgv_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void apply_avg(input int avg);
    int tgt;
    tgt = (avg > ATH) ? 2 : (avg > WTH) ? 1 : 0;
    if (tgt > m_level) begin
      m_deb++;
      if (m_deb >= DEBN) begin m_level = tgt; m_deb = 0; end
    end else begin
      m_deb = 0;
      if (m_level == 2 && avg <= ATH - HY) m_level = (avg <= WTH - HY) ? 0 : 1;
      else if (m_level == 1 && avg <= WTH - HY) m_level = 0;
    end
  endfunction

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic v, input int s);
    int prev, sum;
    @(negedge clk);
    rst = r; sample_valid = v; sample = 10'(s);
    @(posedge clk);
    if (r) begin
      win.delete(); m_avg = 0; m_avgv = 0; m_level = 0; m_deb = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_avgv != 0) begin
        prev = m_level;
        apply_avg(m_avg);
        m_pulse = (m_level == 2 && prev != 2) ? 1 : 0;
      end
      m_avgv = 0;
      if (v) begin
        win.push_back(s);
        if (win.size() == 4) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          m_avg = sum / 4;
          m_avgv = 1;
          win.delete();
        end
      end
    end
    #1;
    check("temp_avg", int'(temp_avg), m_avg);
    check("avg_valid", int'(avg_valid), m_avgv);
    check("level", int'(level), m_level);
    check("led", int'(led), (m_level == 2) ? 3 : (m_level == 1) ? 1 : 0);
    check("alarm_pulse", int'(alarm_pulse), m_pulse);
    pulses_seen += int'(alarm_pulse);
    avgv_seen   += int'(avg_valid);
  endtask

  typedef struct {
    int s[4];
    int exp_avg;
    int exp_level;
    int exp_pulses;
  } win_vec_t;

  win_vec_t tbl[18];

  initial begin
    tbl[0]  = '{'{10, 11, 12, 14}, 11, 0, 0};
    tbl[1]  = '{'{40, 40, 40, 40}, 40, 0, 0};
    tbl[2]  = '{'{30, 30, 30, 30}, 30, 0, 0};
    tbl[3]  = '{'{40, 40, 40, 40}, 40, 0, 0};
    tbl[4]  = '{'{40, 40, 40, 40}, 40, 1, 0};
    tbl[5]  = '{'{70, 70, 70, 70}, 70, 1, 0};
    tbl[6]  = '{'{70, 70, 70, 70}, 70, 2, 1};
    tbl[7]  = '{'{70, 70, 70, 70}, 70, 2, 0};
    tbl[8]  = '{'{59, 59, 59, 59}, 59, 2, 0};
    tbl[9]  = '{'{58, 58, 58, 58}, 58, 1, 0};
    tbl[10] = '{'{36, 36, 36, 36}, 36, 1, 0};
    tbl[11] = '{'{35, 35, 35, 35}, 35, 0, 0};
    tbl[12] = '{'{37, 37, 37, 37}, 37, 0, 0};
    tbl[13] = '{'{37, 37, 37, 37}, 37, 0, 0};
    tbl[14] = '{'{60, 61, 60, 61}, 60, 0, 0};
    tbl[15] = '{'{61, 61, 62, 62}, 61, 2, 1};
    tbl[16] = '{'{20, 20, 20, 20}, 20, 0, 0};
    tbl[17] = '{'{1023, 1023, 1023, 1022}, 1022, 0, 0};

    // reset held with sample_valid toggling
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 100 + i);
    check("rst_level", int'(level), 0);
    check("rst_avg", int'(temp_avg), 0);
    avgv_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5);
    check("no_early_avg", avgv_seen, 0);
    step(1'b0, 1'b1, 5);
    check("first_avg_valid", int'(avg_valid), 1);
    check("first_avg", int'(temp_avg), 5);
    step(1'b1, 1'b0, 0);

    // table of whole windows: 4 back-to-back samples then 2 idle cycles
    for (int k = 0; k < 18; k++) begin
      pulses_seen = 0; avgv_seen = 0;
      for (int j = 0; j < 4; j++) step(1'b0, 1'b1, tbl[k].s[j]);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      check($sformatf("tbl%0d_avg", k), int'(temp_avg), tbl[k].exp_avg);
      check($sformatf("tbl%0d_level", k), int'(level), tbl[k].exp_level);
      check($sformatf("tbl%0d_pulses", k), pulses_seen, tbl[k].exp_pulses);
      check($sformatf("tbl%0d_avgv", k), avgv_seen, 1);
    end

    // reset mid-window while in ALARM
    for (int w = 0; w < 2; w++) for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 70);
    step(1'b0, 1'b0, 0); step(1'b0, 1'b0, 0);
    check("mid_alarm_level", int'(level), 2);
    step(1'b0, 1'b1, 70); step(1'b0, 1'b1, 70);
    step(1'b1, 1'b1, 70);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_led", int'(led), 0);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 5);
    check("mid_rst_avg", int'(temp_avg), 5);
    check("mid_rst_avgv", int'(avg_valid), 1);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(10, 90));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
